// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM BIST controller: FSM state encoding,
// default widths and the expected-data pattern generator.
package ram_bist_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Callers truncate the result to their data width, which gives the mod 2^DATA_W.
    function automatic logic [31:0] exp_pattern(input logic [31:0] addr, input logic [31:0] seed);
        return (addr << 1) + seed;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker for the RAM BIST: registered compare, mismatch counter,
// first-failure capture and final pass flag.
module ram_bist_cmp #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_finish,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_pass,
    output logic [ADDR_W:0]   o_err_count,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_data
);

    logic              r_pass;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic              w_mismatch;

    assign w_mismatch = i_en && (i_rdata != i_exp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (i_clear) begin
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            if (w_mismatch) begin
                r_err_count <= r_err_count + 1'b1;
                // Capture address and data only while the error count is still zero.
                if (r_err_count == '0) begin
                    r_fail_addr <= i_addr;
                    r_fail_data <= i_rdata;
                end
            end
            // The last compare lands on the same edge, so fold it in here.
            if (i_finish) begin
                r_pass <= (r_err_count == '0) && !w_mismatch;
            end
        end
    end

    assign o_pass      = r_pass;
    assign o_err_count = r_err_count;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_data = r_fail_data;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST initiator: fills the RAM with a seeded pattern, reads it back through
// a one-deep read pipeline and reports pass/fail via the compare sub-module.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cs,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_seed;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cs;
    logic              r_wr;
    logic              r_rd;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_cmp_addr;

    logic              w_start_acc;
    logic [DATA_W-1:0] w_exp_cmp;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_exp_cmp   = DATA_W'(exp_pattern(32'(r_cmp_addr), 32'(r_seed)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_seed     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cs       <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_cmp_addr <= '0;
        end else begin
            r_done     <= 1'b0;
            // Read data returns one cycle after the request; remember what it was for.
            r_rd_pend  <= (r_state == ST_READ);
            r_cmp_addr <= r_addr;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_WRITE;
                        r_seed  <= seed;
                        r_addr  <= '0;
                        r_wdata <= DATA_W'(exp_pattern(32'd0, 32'(seed)));
                        r_cs    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_addr == LAST_ADDR) begin
                        r_state <= ST_READ;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_wdata <= DATA_W'(exp_pattern(32'(r_addr + 1'b1), 32'(r_seed)));
                    end
                end
                ST_READ: begin
                    if (r_addr == LAST_ADDR) begin
                        r_state <= ST_DRAIN;
                        r_addr  <= '0;
                        r_cs    <= 1'b0;
                        r_rd    <= 1'b0;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (w_start_acc),
        .i_en        (r_rd_pend),
        .i_finish    (r_state == ST_DRAIN),
        .i_addr      (r_cmp_addr),
        .i_exp       (w_exp_cmp),
        .i_rdata     (mem_rdata),
        .o_pass      (pass),
        .o_err_count (err_count),
        .o_fail_addr (fail_addr),
        .o_fail_data (fail_data)
    );

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_cs    = r_cs;
    assign mem_wr    = r_wr;
    assign mem_rd    = r_rd;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Synchronous initiator for the single-port 1024x8 RAM (addr/data/cs/wr/rd, write on posedge, registered read). On `start` it fills every location with a seeded pattern, reads all locations back, and compares against the expected pattern. It reports pass/fail, the first failing address and data, and the mismatch count. It sits between the test/system sequencer and the RAM, and is the driving end of the RAM's port.

## Interface
Parameters:
- `ADDR_W`, 10, address width
- `DATA_W`, 8, data width
- `DEPTH`, 1024, locations tested (≤ 2^ADDR_W, ≥ 2)

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: begin a test (sampled in IDLE only)
- `seed` in DATA_W: pattern seed, latched on accepted `start`
- `mem_addr` out ADDR_W: RAM address
- `mem_wdata` out DATA_W: RAM write data
- `mem_rdata` in DATA_W: RAM read data (valid one cycle after a read request)
- `mem_cs`, `mem_wr`, `mem_rd` out 1: RAM chip-select, write, and read strobes
- `busy` out 1: test in progress
- `done` out 1: one-cycle pulse at test end
- `pass` out 1: last test had zero mismatches
- `err_count` out ADDR_W+1: mismatches in last test
- `fail_addr` out ADDR_W: address of first mismatch
- `fail_data` out DATA_W: data read at first mismatch

## Operation
- Expected pattern: `exp(a) = (2*a + seed_q) mod 2^DATA_W`.
- States:
  - IDLE: strobes low, `busy`=0. `start`=1 → latch seed, clear `err_count`/`pass`/`fail_*`, go to WRITE with addr=0.
  - WRITE: `mem_cs`=1, `mem_wr`=1, `mem_rd`=0, `mem_wdata`=exp(addr). Addr increments each cycle. After addr DEPTH-1 → READ, addr=0.
  - READ: `mem_cs`=1, `mem_rd`=1, `mem_wr`=0. Addr increments each cycle. The compare for addr a-1 occurs in the same cycle addr a is issued (one-deep pipeline). After DEPTH-1 → DRAIN.
  - DRAIN: strobes low; compare for addr DEPTH-1.
  - DONE: `done`=1 for one cycle; `pass`=(err_count==0); → IDLE.
- On mismatch:
  - `err_count`+1 (cannot overflow, max DEPTH).
  - If this is the first mismatch, capture `fail_addr`/`fail_data`; later mismatches do not overwrite them.
- `mem_wr` and `mem_rd` are never high together. `mem_cs`=0 whenever both are low.
- `start` while busy is ignored. `start` held high in DONE/IDLE retriggers on the IDLE cycle.
- Results (`pass`, `err_count`, `fail_*`) hold until the next accepted `start`.
- Address counter wraps only by state change; it never exceeds DEPTH-1.

## Timing
- Reset values: state IDLE; all outputs 0 (`mem_addr`, `mem_wdata`, strobes, `busy`, `done`, `pass`, `err_count`, `fail_*`).
- Start accepted at edge E0 → cycle 1 is the first WRITE (addr 0).
- Cycle timeline:
  - WRITE: cycles 1..DEPTH
  - READ: cycles DEPTH+1..2·DEPTH
  - DRAIN: cycle 2·DEPTH+1
  - DONE: cycle 2·DEPTH+2 (`done`=1, `busy`=0)
- `busy`=1 in cycles 1..2·DEPTH+1.
- `mem_rdata` for a read issued in cycle n is sampled at the edge ending cycle n+1.
- All memory outputs are registered: no combinational path from `mem_rdata` to any output.
- Reset asserted mid-test: immediately return to IDLE with all outputs 0; results are lost.

## Structure
- Package `ram_bist_pkg`:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE)
  - default width constants
  - function `exp_pattern(addr, seed)`
- One sub-module, `ram_bist_cmp`: registered compare, error counter, and first-fail capture; clear and enable come from the FSM.

## Test plan
- Clean RAM model, DEPTH=1024, seed=0:
  - `done` at cycle 2050 after start; `pass`=1, `err_count`=0.
  - Location 5 holds 10; location 200 holds 144.
- Seed=8'h03, location 7 model stuck at 8'h00:
  - `pass`=0, `err_count`=1, `fail_addr`=7, `fail_data`=0.
- Bit 0 stuck-at-1 on all locations, seed=0:
  - `err_count`=1024, `fail_addr`=0, `fail_data`=8'h01.
- Strobe protocol checker over a full run:
  - `mem_wr`&`mem_rd` never both 1.
  - Exactly 1024 write cycles, then 1024 read cycles.
  - `mem_cs` low in IDLE/DRAIN/DONE.
- Pulse `start` at cycle 500 of a run → ignored; `done` still at cycle 2050.
- Assert `rst_n`=0 at cycle 1500, release, then start again:
  - Outputs 0 during reset; the second run completes with `pass`=1.
